// File: rtl/carregador_matriz_pkg.sv
// matriz_pkg: shared constants, FSM state encoding, size decode and lane index helpers
package matriz_pkg;
  localparam int ELEM_W = 8;
  localparam int MAX_DIM = 5;
  localparam int MATRIX_W = MAX_DIM * MAX_DIM * ELEM_W;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [2:0] size_n(input logic [1:0] code);
    return {1'b0, code} + 3'd2;
  endfunction
  function automatic logic [4:0] idx(input logic [2:0] r, input logic [2:0] c);
    return {2'b00, r} * 5'd5 + {2'b00, c};
  endfunction
endpackage

// File: rtl/carregador_matriz_contador.sv
// contador_linha_coluna: row-major row/col counter (clk, reset, clear, advance, n -> row, col, last on final cell)
module contador_linha_coluna
  import matriz_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  logic [2:0] n,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);
  logic last_col;
  assign last_col = col == n - 3'd1;
  assign last = last_col && row == n - 3'd1;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      col <= last_col ? 3'd0 : col + 3'd1;
      row <= last_col ? row + 3'd1 : row;
    end
  end
endmodule

// File: rtl/carregador_matriz.sv
// carregador_matriz: loads an NxN int8 matrix from a valid/ready byte stream into 25 packed lanes (start/matrix_size/transpose_en in; in_ready, matrix_out, busy, done out)
module carregador_matriz
  import matriz_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          matrix_size,
  input  logic                transpose_en,
  input  logic                in_valid,
  input  logic [ELEM_W-1:0]   in_data,
  output logic                in_ready,
  output logic [MATRIX_W-1:0] matrix_out,
  output logic                busy,
  output logic                done
);
  state_t     state, nxt;
  logic [2:0] n, row, col;
  logic [4:0] lane;
  logic       tr, last, accept, begin_load;
  assign begin_load = state == IDLE && start;
  assign in_ready = state == LOAD;
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign lane = tr ? idx(col, row) : idx(row, col);
  contador_linha_coluna u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (begin_load),
    .advance (accept),
    .n       (n),
    .row     (row),
    .col     (col),
    .last    (last)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE ? (start ? LOAD : IDLE) :
          state == LOAD ? (accept && last ? DONE : LOAD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      n  <= 3'd2;
      tr <= 1'b0;
    end else if (begin_load) begin
      n  <= size_n(matrix_size);
      tr <= transpose_en;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || begin_load) matrix_out <= '0;
    else if (accept) matrix_out[lane*ELEM_W +: ELEM_W] <= in_data;
  end
endmodule

// File: tb/tb_carregador_matriz.sv
// tb_carregador_matriz: scoreboard bench with a lane-array reference model for carregador_matriz
module tb_carregador_matriz;
  logic         clk = 0, reset = 1, start = 0, transpose_en = 0, in_valid = 0;
  logic [1:0]   matrix_size = 0;
  logic [7:0]   in_data = 0;
  logic         in_ready, busy, done;
  logic [199:0] matrix_out;
  logic [199:0] expq[$];
  logic [7:0]   dq[$];
  int total = 0, bad = 0;

  carregador_matriz dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .matrix_size  (matrix_size),
    .transpose_en (transpose_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .matrix_out   (matrix_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] model(input int n, input bit tr);
    logic [7:0]   lanes[25];
    logic [199:0] m;
    int r, c;
    foreach (lanes[k]) lanes[k] = 8'h00;
    for (int i = 0; i < n * n; i++) begin
      r = i / n;
      c = i % n;
      if (tr) lanes[c * 5 + r] = dq[i];
      else lanes[r * 5 + c] = dq[i];
    end
    m = '0;
    for (int k = 0; k < 25; k++) m[k*8 +: 8] = lanes[k];
    return m;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else check("matrix", matrix_out, expq.pop_front());
    end
  end

  task automatic run_load(input logic [1:0] code, input bit tr, input bit gaps, input bit noise);
    logic [199:0] e;
    int n;
    n = int'(code) + 2;
    e = model(n, tr);
    check("idle_ready", {199'd0, in_ready}, 200'd0);
    expq.push_back(e);
    start = 1;
    matrix_size = code;
    transpose_en = tr;
    in_valid = 1;
    in_data = 8'h5a;
    tick;
    start = 0;
    matrix_size = 2'($urandom);
    transpose_en = 1'($urandom);
    check("cleared", matrix_out, 200'd0);
    check("load_ready", {199'd0, in_ready}, 200'd1);
    for (int i = 0; i < n * n; i++) begin
      if (gaps || (noise && $urandom_range(3) == 0)) begin
        in_valid = 0;
        in_data = 8'($urandom);
        tick;
      end
      in_valid = 1;
      in_data = dq[i];
      if (noise) begin
        start = 1'($urandom);
        matrix_size = 2'($urandom);
        transpose_en = 1'($urandom);
      end
      tick;
    end
    in_valid = 0;
    start = 0;
    check("done_pulse", {199'd0, done}, 200'd1);
    check("done_ready", {199'd0, in_ready}, 200'd0);
    tick;
    check("done_drop", {199'd0, done}, 200'd0);
    check("idle_busy", {199'd0, busy}, 200'd0);
    check("held", matrix_out, e);
  endtask

  task automatic fill_seq(input int n, input int base);
    dq.delete();
    for (int i = 0; i < n * n; i++) dq.push_back(8'(base + i));
  endtask

  task automatic fill_rand(input int n);
    dq.delete();
    for (int i = 0; i < n * n; i++) dq.push_back(8'($urandom));
  endtask

  initial begin
    logic [1:0] code;
    repeat (3) tick;
    check("rst_ready", {199'd0, in_ready}, 200'd0);
    check("rst_busy", {199'd0, busy}, 200'd0);
    check("rst_done", {199'd0, done}, 200'd0);
    check("rst_matrix", matrix_out, 200'd0);
    reset = 0;
    tick;
    fill_seq(2, 1);
    run_load(2'd0, 1'b0, 1'b0, 1'b0);
    fill_seq(3, 1);
    run_load(2'd1, 1'b1, 1'b0, 1'b0);
    fill_seq(5, -128);
    run_load(2'd3, 1'b0, 1'b1, 1'b0);
    start = 1;
    matrix_size = 2'd2;
    transpose_en = 0;
    tick;
    start = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = 8'(i + 40);
      tick;
    end
    in_valid = 0;
    reset = 1;
    tick;
    reset = 0;
    check("abort_matrix", matrix_out, 200'd0);
    check("abort_busy", {199'd0, busy}, 200'd0);
    check("abort_done", {199'd0, done}, 200'd0);
    tick;
    fill_rand(2);
    run_load(2'd0, 1'($urandom), 1'b0, 1'b0);
    fill_seq(3, 11);
    run_load(2'd1, 1'b0, 1'b0, 1'b1);
    fill_rand(5);
    run_load(2'd3, 1'($urandom), 1'b0, 1'b0);
    fill_rand(2);
    run_load(2'd0, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 15; t++) begin
      code = 2'($urandom);
      fill_rand(int'(code) + 2);
      run_load(code, 1'($urandom), 1'($urandom), 1'b1);
    end
    tick;
    check("sb_empty", 200'(expq.size()), 200'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
